// File: rtl/fakeram_arb_pkg.sv
// fakeram_arb_pkg
//   Shared types and helpers for the dual-port fakeram arbiter.
//   - state_t     : INIT (zero-fill) / RUN (admit traffic)
//   - port_tag_t  : per-RAM-port response tag {valid, requester index, we}
//   - rr_pick     : cyclic first-valid search from a one-hot pointer,
//                   skipping excluded requesters; returns {found, index}
package fakeram_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             we;
  } port_tag_t;

  // Only the low n bits of each mask are meaningful; the search wraps at n.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [MAX_NREQ-1:0] ptr,
    input logic [MAX_NREQ-1:0] excl,
    input int unsigned         n
  );
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    start   = '0;
    j       = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < n && ptr[IDX_W'(i)]) start = IDX_W'(i);
    end
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      if (k < n) begin
        j = IDX_W'((32'(start) + k) % n);
        if (!found && valid[j] && !excl[j]) begin
          found   = 1'b1;
          win_idx = j;
        end
      end
    end
    return {found, win_idx};
  endfunction

endpackage

// File: rtl/fakeram_rr_pick.sv
// fakeram_rr_pick
//   Combinational round-robin picker: one-hot winner among valid requesters,
//   searching cyclically from the one-hot pointer and skipping excluded ones.
//   Ports:
//     valid  [NREQ] requesters eligible this cycle
//     ptr    [NREQ] one-hot search start
//     excl   [NREQ] requesters that may not win
//     winner [NREQ] one-hot winner, all zero when nobody qualifies
module fakeram_rr_pick
  import fakeram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] ptr,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] winner
);

  logic [MAX_NREQ-1:0] valid_w;
  logic [MAX_NREQ-1:0] ptr_w;
  logic [MAX_NREQ-1:0] excl_w;
  logic [IDX_W:0]      pick;

  always_comb begin
    valid_w = '0;
    ptr_w   = '0;
    excl_w  = '0;
    valid_w[NREQ-1:0] = valid;
    ptr_w[NREQ-1:0]   = ptr;
    excl_w[NREQ-1:0]  = excl;
    pick   = rr_pick(valid_w, ptr_w, excl_w, NREQ);
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick[IDX_W] && pick[IDX_W-1:0] == IDX_W'(k)) winner[k] = 1'b1;
    end
  end

endmodule

// File: rtl/fakeram_dp_arbiter.sv
// fakeram_dp_arbiter
//   Shares both ports of a dual-port fakeram macro among NREQ requesters with
//   round-robin arbitration (up to two grants per cycle, one per port). After
//   reset or a clear_in pulse the whole array is zero-filled two words per
//   cycle before traffic is admitted. Read data returns one cycle after grant.
//   Option: define FAKERAM_ARB_COLLISION_EN to withhold the port-1 grant when
//   both winners hit the same address and either one writes.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     clear_in                   restart zero-fill (honoured in RUN only)
//     init_done_out              high in RUN
//     req_valid/ready/we         per-requester handshake and write flag
//     req_addr_in, req_wd_in     packed per-requester address / write data
//     rsp_valid_out, rsp_rd_out  per-requester response strobe / read data
//     rw0_*, rw1_*               macro port 0 / port 1 drive and read data
module fakeram_dp_arbiter
  import fakeram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned BITS       = 16,
  parameter int unsigned WORD_DEPTH = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_in,
  output logic                       init_done_out,
  input  logic [NREQ-1:0]            req_valid_in,
  output logic [NREQ-1:0]            req_ready_out,
  input  logic [NREQ-1:0]            req_we_in,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NREQ*BITS-1:0]       req_wd_in,
  output logic [NREQ-1:0]            rsp_valid_out,
  output logic [NREQ*BITS-1:0]       rsp_rd_out,
  output logic                       rw0_ce_out,
  output logic                       rw0_we_out,
  output logic [ADDR_WIDTH-1:0]      rw0_addr_out,
  output logic [BITS-1:0]            rw0_wd_out,
  input  logic [BITS-1:0]            rw0_rd_in,
  output logic                       rw1_ce_out,
  output logic                       rw1_we_out,
  output logic [ADDR_WIDTH-1:0]      rw1_addr_out,
  output logic [BITS-1:0]            rw1_wd_out,
  input  logic [BITS-1:0]            rw1_rd_in
);

  localparam int unsigned CW = (WORD_DEPTH > 2) ? $clog2(WORD_DEPTH / 2) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [NREQ-1:0] ptr_q, ptr_d;
  port_tag_t       tag0_q, tag1_q;

  logic [NREQ-1:0] eligible, no_excl, ptr1;
  logic [NREQ-1:0] gnt0, gnt1_raw, gnt1;
  logic [IDX_W-1:0] idx0, idx1;
  logic            we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [BITS-1:0] wd0, wd1;
  logic            fill_last;

  // No grants outside RUN, nor in the cycle a clear is requested.
  assign eligible  = (state_q == RUN && !clear_in) ? req_valid_in : '0;
  assign no_excl   = '0;
  // Port 1 searches from the requester just after the port-0 winner.
  assign ptr1      = {gnt0[NREQ-2:0], gnt0[NREQ-1]};
  assign fill_last = (fill_q == CW'(WORD_DEPTH / 2 - 1));

  fakeram_rr_pick #(.NREQ(NREQ)) u_pick0 (
    .valid  (eligible),
    .ptr    (ptr_q),
    .excl   (no_excl),
    .winner (gnt0)
  );

  fakeram_rr_pick #(.NREQ(NREQ)) u_pick1 (
    .valid  (eligible),
    .ptr    (ptr1),
    .excl   (gnt0),
    .winner (gnt1_raw)
  );

  always_comb begin
    idx0  = '0;
    we0   = 1'b0;
    addr0 = '0;
    wd0   = '0;
    idx1  = '0;
    we1   = 1'b0;
    addr1 = '0;
    wd1   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt0[k]) begin
        idx0  = IDX_W'(k);
        we0   = req_we_in[k];
        addr0 = req_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
        wd0   = req_wd_in[k*BITS +: BITS];
      end
      if (gnt1_raw[k]) begin
        idx1  = IDX_W'(k);
        we1   = req_we_in[k];
        addr1 = req_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
        wd1   = req_wd_in[k*BITS +: BITS];
      end
    end
  end

`ifdef FAKERAM_ARB_COLLISION_EN
  logic clash;
  assign clash = (|gnt1_raw) && (addr0 == addr1) && (we0 || we1);
  assign gnt1  = clash ? '0 : gnt1_raw;
`else
  assign gnt1  = gnt1_raw;
`endif

  assign req_ready_out = gnt0 | gnt1;
  assign init_done_out = (state_q == RUN);

  // Pointer moves one past the last requester actually granted.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt1)      ptr_d = {gnt1[NREQ-2:0], gnt1[NREQ-1]};
    else if (|gnt0) ptr_d = {gnt0[NREQ-2:0], gnt0[NREQ-1]};
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      INIT: begin
        fill_d = fill_q + CW'(1);
        if (fill_last) begin
          state_d = RUN;
          fill_d  = '0;
        end
      end
      RUN: begin
        if (clear_in) begin
          state_d = INIT;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = INIT;
        fill_d  = '0;
      end
    endcase
  end

  // Macro drive is combinational so read data lands one edge after grant;
  // it is forced idle while reset is held (state alone would show a fill).
  always_comb begin
    rw0_ce_out   = 1'b0;
    rw0_we_out   = 1'b0;
    rw0_addr_out = '0;
    rw0_wd_out   = '0;
    rw1_ce_out   = 1'b0;
    rw1_we_out   = 1'b0;
    rw1_addr_out = '0;
    rw1_wd_out   = '0;
    if (rst_n) begin
      if (state_q == INIT) begin
        rw0_ce_out   = 1'b1;
        rw0_we_out   = 1'b1;
        rw0_addr_out = ADDR_WIDTH'({fill_q, 1'b0});
        rw1_ce_out   = 1'b1;
        rw1_we_out   = 1'b1;
        rw1_addr_out = ADDR_WIDTH'({fill_q, 1'b1});
      end else begin
        if (|gnt0) begin
          rw0_ce_out   = 1'b1;
          rw0_we_out   = we0;
          rw0_addr_out = addr0;
          rw0_wd_out   = wd0;
        end
        if (|gnt1) begin
          rw1_ce_out   = 1'b1;
          rw1_we_out   = we1;
          rw1_addr_out = addr1;
          rw1_wd_out   = wd1;
        end
      end
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    rsp_rd_out    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (tag0_q.valid && tag0_q.idx == IDX_W'(k)) begin
        rsp_valid_out[k] = 1'b1;
        if (!tag0_q.we) rsp_rd_out[k*BITS +: BITS] = rw0_rd_in;
      end
      if (tag1_q.valid && tag1_q.idx == IDX_W'(k)) begin
        rsp_valid_out[k] = 1'b1;
        if (!tag1_q.we) rsp_rd_out[k*BITS +: BITS] = rw1_rd_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      fill_q  <= '0;
      ptr_q   <= NREQ'(1);
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      tag0_q  <= '{valid: |gnt0, idx: idx0, we: we0};
      tag1_q  <= '{valid: |gnt1, idx: idx1, we: we1};
    end
  end

endmodule

// File: tb/tb_fakeram_dp_arbiter.sv
// tb_fakeram_dp_arbiter
//   Drives fakeram_dp_arbiter with directed and random traffic against a
//   behavioural RAM; expectations come from an index-based round-robin model
//   and a reference memory kept in the bench.
module tb_fakeram_dp_arbiter;

  localparam int NREQ  = 4;
  localparam int BITS  = 16;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear_in;
  logic                 init_done_out;
  logic [NREQ-1:0]      req_valid_in, req_ready_out, req_we_in;
  logic [NREQ*AW-1:0]   req_addr_in;
  logic [NREQ*BITS-1:0] req_wd_in;
  logic [NREQ-1:0]      rsp_valid_out;
  logic [NREQ*BITS-1:0] rsp_rd_out;
  logic                 rw0_ce_out, rw0_we_out, rw1_ce_out, rw1_we_out;
  logic [AW-1:0]        rw0_addr_out, rw1_addr_out;
  logic [BITS-1:0]      rw0_wd_out, rw1_wd_out, rw0_rd_in, rw1_rd_in;

  always #5 clk = ~clk;

  fakeram_dp_arbiter #(.NREQ(NREQ), .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .init_done_out(init_done_out),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_we_in(req_we_in),
    .req_addr_in(req_addr_in), .req_wd_in(req_wd_in),
    .rsp_valid_out(rsp_valid_out), .rsp_rd_out(rsp_rd_out),
    .rw0_ce_out(rw0_ce_out), .rw0_we_out(rw0_we_out), .rw0_addr_out(rw0_addr_out),
    .rw0_wd_out(rw0_wd_out), .rw0_rd_in(rw0_rd_in),
    .rw1_ce_out(rw1_ce_out), .rw1_we_out(rw1_we_out), .rw1_addr_out(rw1_addr_out),
    .rw1_wd_out(rw1_wd_out), .rw1_rd_in(rw1_rd_in)
  );

  // Behavioural dual-port macro: registered read, write committed at the edge.
  logic [BITS-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (rw0_ce_out) begin
      if (rw0_we_out) ram[rw0_addr_out] <= rw0_wd_out;
      else            rw0_rd_in <= ram[rw0_addr_out];
    end
    if (rw1_ce_out) begin
      if (rw1_we_out) ram[rw1_addr_out] <= rw1_wd_out;
      else            rw1_rd_in <= ram[rw1_addr_out];
    end
  end

  // Reference model state.
  logic [BITS-1:0]      ref_mem [DEPTH];
  int                   ptr;
  logic [NREQ-1:0]      exp_rv;
  logic [NREQ*BITS-1:0] exp_rd;
  logic [AW-1:0]        st_addr [NREQ];
  logic [BITS-1:0]      st_wd   [NREQ];
  int                   tests;
  int                   fails;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_done", 64'(init_done_out), 64'd0);
    check("rst_ready", 64'(req_ready_out), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
    check("rst_rsp_rd", 64'(rsp_rd_out), 64'd0);
    check("rst_rw0", 64'({rw0_ce_out, rw0_we_out, rw0_addr_out, rw0_wd_out}), 64'd0);
    check("rst_rw1", 64'({rw1_ce_out, rw1_we_out, rw1_addr_out, rw1_wd_out}), 64'd0);
  endtask

  // One RUN cycle: apply inputs, predict grants/drive, compare, advance model.
  task automatic run_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w, input logic clr,
                           input logic chk, input logic [NREQ-1:0] want);
    int g0, g1, j;
    logic [NREQ-1:0] er, nrv;
    logic [NREQ*BITS-1:0] nrd;
    logic [29:0] e0, e1;
    req_valid_in = v;
    req_we_in    = w;
    clear_in     = clr;
    for (int i = 0; i < NREQ; i++) begin
      req_addr_in[i*AW +: AW]     = st_addr[i];
      req_wd_in[i*BITS +: BITS]   = st_wd[i];
    end
    g0 = -1;
    g1 = -1;
    if (!clr) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr + k) % NREQ;
        if (g0 < 0 && v[j]) g0 = j;
      end
      if (g0 >= 0)
        for (int k = 1; k < NREQ; k++) begin
          j = (g0 + k) % NREQ;
          if (g1 < 0 && v[j]) g1 = j;
        end
`ifdef FAKERAM_ARB_COLLISION_EN
      if (g1 >= 0 && st_addr[g0] == st_addr[g1] && (w[g0] || w[g1])) g1 = -1;
`endif
    end
    er = '0;
    e0 = '0;
    e1 = '0;
    if (g0 >= 0) begin er[g0] = 1'b1; e0 = {1'b1, w[g0], st_addr[g0], st_wd[g0]}; end
    if (g1 >= 0) begin er[g1] = 1'b1; e1 = {1'b1, w[g1], st_addr[g1], st_wd[g1]}; end
    @(negedge clk);
    check("ready", 64'(req_ready_out), 64'(er));
    if (chk) check("dir_ready", 64'(req_ready_out), 64'(want));
    check("rsp_valid", 64'(rsp_valid_out), 64'(exp_rv));
    check("rsp_rd", 64'(rsp_rd_out), 64'(exp_rd));
    check("rw0", 64'({rw0_ce_out, rw0_we_out, rw0_addr_out, rw0_wd_out}), 64'(e0));
    check("rw1", 64'({rw1_ce_out, rw1_we_out, rw1_addr_out, rw1_wd_out}), 64'(e1));
    check("init_done", 64'(init_done_out), 64'd1);
    nrv = '0;
    nrd = '0;
    if (g0 >= 0) begin
      nrv[g0] = 1'b1;
      if (!w[g0]) nrd[g0*BITS +: BITS] = ref_mem[st_addr[g0]];
    end
    if (g1 >= 0) begin
      nrv[g1] = 1'b1;
      if (!w[g1]) nrd[g1*BITS +: BITS] = ref_mem[st_addr[g1]];
    end
    if (g0 >= 0 && w[g0]) ref_mem[st_addr[g0]] = st_wd[g0];
    if (g1 >= 0 && w[g1]) ref_mem[st_addr[g1]] = st_wd[g1];
    exp_rv = nrv;
    exp_rd = nrd;
    if (g1 >= 0)      ptr = (g1 + 1) % NREQ;
    else if (g0 >= 0) ptr = (g0 + 1) % NREQ;
    @(posedge clk);
    #1;
  endtask

  // Zero-fill phase; stop_at >= 0 abandons the fill at that cycle index.
  task automatic do_fill(input int stop_at);
    for (int k = 0; k < DEPTH / 2; k++) begin
      if (k == stop_at) return;
      req_valid_in = NREQ'($urandom);
      req_we_in    = NREQ'($urandom);
      clear_in     = (k == 7);
      @(negedge clk);
      check("fill_ready", 64'(req_ready_out), 64'd0);
      check("fill_done", 64'(init_done_out), 64'd0);
      check("fill_rsp", 64'(rsp_valid_out), 64'(exp_rv));
      check("fill_rw0", 64'({rw0_ce_out, rw0_we_out, rw0_addr_out, rw0_wd_out}),
            64'({2'b11, AW'(2 * k), {BITS{1'b0}}}));
      check("fill_rw1", 64'({rw1_ce_out, rw1_we_out, rw1_addr_out, rw1_wd_out}),
            64'({2'b11, AW'(2 * k + 1), {BITS{1'b0}}}));
      exp_rv = '0;
      exp_rd = '0;
      @(posedge clk);
      #1;
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    req_valid_in = '0;
    req_we_in    = '0;
    clear_in     = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    ptr    = 0;
    exp_rv = '0;
    exp_rd = '0;
    for (int a = 0; a < DEPTH; a++) ram[a] <= BITS'($urandom);
    for (int i = 0; i < NREQ; i++) begin st_addr[i] = '0; st_wd[i] = '0; end
    rst_n        = 1'b0;
    clear_in     = 1'b0;
    req_valid_in = '1;
    req_we_in    = '0;
    req_addr_in  = '0;
    req_wd_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_fill(-1);

    // Freshly filled word reads back as zero.
    st_addr[0] = 12'h005;
    run_cycle(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001);
    check("rd005_valid", 64'(rsp_valid_out[0]), 64'd1);
    check("rd005_data", 64'(rsp_rd_out[0 +: BITS]), 64'd0);

    // Write then read of the same word by different requesters.
    st_addr[1] = 12'h123; st_wd[1] = 16'hBEEF;
    run_cycle(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010);
    st_addr[2] = 12'h123;
    run_cycle(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100);
    check("beef_valid", 64'(rsp_valid_out[2]), 64'd1);
    check("beef_data", 64'(rsp_rd_out[2*BITS +: BITS]), 64'hBEEF);

    // Bring the pointer back to requester 0, then all four compete.
    st_addr[3] = 12'h007;
    run_cycle(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < NREQ; i++) st_addr[i] = AW'(12'h200 + i);
    run_cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0011);
    run_cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1100);
    run_cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0011);

    // Same-address writes from requesters 0 and 1.
    run_cycle(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000);
    st_addr[0] = 12'h040; st_wd[0] = 16'h1234;
    st_addr[1] = 12'h040; st_wd[1] = 16'h1234;
`ifdef FAKERAM_ARB_COLLISION_EN
    run_cycle(4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0001);
    run_cycle(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010);
`else
    run_cycle(4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0011);
`endif
    st_addr[2] = 12'h040;
    run_cycle(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Random traffic; each requester stays inside its own address region.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        st_addr[i] = {2'(i), 4'b0000, 6'($urandom)};
        st_wd[i]   = BITS'($urandom);
      end
      run_cycle(NREQ'($urandom), NREQ'($urandom), 1'b0, 1'b0, 4'b0000);
    end

    // Clear with a read in flight: response still delivered, then refill.
    st_addr[0] = 12'h123;
    run_cycle(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000);
    run_cycle(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000);
    do_fill(-1);
    run_cycle(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000);
    run_cycle(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Reset in the middle of a fill, then a complete fill from address 0.
    run_cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000);
    do_fill(1000);
    rst_n        = 1'b0;
    req_valid_in = '1;
    @(negedge clk);
    check_reset();
    ptr    = 0;
    exp_rv = '0;
    exp_rd = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_fill(-1);
    for (int i = 0; i < NREQ; i++) st_addr[i] = AW'(12'h300 + i);
    run_cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0011);
    run_cycle(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
